key_value_mod: RTL

//  Input-side counterpart of the 7-segment display chain: turns the four raw board keys

---
 rtl/key_value_mod_pkg.sv | 9 +
 rtl/key_value_mod_debounce.sv | 38 +++
 rtl/key_value_mod.sv | 63 ++++++
 3 files changed

// File: rtl/key_value_mod_pkg.sv
// key_value_mod_pkg: key index constants and debounce defaults shared by the key path
package key_value_mod_pkg;
  localparam int KEY_INC = 0;
  localparam int KEY_DEC = 1;
  localparam int KEY_ADD10 = 2;
  localparam int KEY_CLR = 3;
  localparam int DEBOUNCE_SYN = 1_000_000;
  localparam int DEBOUNCE_SIM = 8;
endpackage

// File: rtl/key_value_mod_debounce.sv
// key_debounce_mod: one key - 2-FF sync, debounce counter, debounced level, press pulse
//   i_clk, i_rst (sync, active-high), i_key_n (raw, active-low, async)
//   o_state: debounced level (1 = pressed), o_press: one-cycle pulse on accepted press
module key_debounce_mod #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_state,
  output logic o_press
);
  logic r_sync1, r_sync2, r_state, r_press;
  logic [CNT_W-1:0] r_cnt;
  logic w_s, w_diff, w_done;
  assign w_s = ~r_sync2;
  assign w_diff = w_s ^ r_state;
  // the DEBOUNCE_CYCLES-th consecutive differing sample commits the new level
  assign w_done = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt <= '0;
      r_state <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_cnt <= (!w_diff || w_done) ? '0 : r_cnt + CNT_W'(1);
      r_state <= w_done ? w_s : r_state;
      r_press <= w_done & w_s;
    end
  end
  assign o_state = r_state;
  assign o_press = r_press;
endmodule

// File: rtl/key_value_mod.sv
// key_value_mod: four debounced keys driving an 8-bit value (inc/dec/+10/clear, wrapping)
//   CLK, RST (sync, active-high), KEY_n[3:0] raw active-low keys
//   key_state: debounced levels, key_press: press pulses
//   value: 0..MAX_VALUE, value_chg: pulse when value takes a new value
module key_value_mod
  import key_value_mod_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SYN,
  parameter int CNT_W = 20,
  parameter int MAX_VALUE = 99,
  parameter int INIT_VALUE = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] KEY_n,
  output logic [3:0] key_state,
  output logic [3:0] key_press,
  output logic [7:0] value,
  output logic       value_chg
);
  localparam logic [8:0] MAX9 = 9'(MAX_VALUE);
  logic [3:0] w_press;
  logic [8:0] w_v9, w_add9;
  logic [7:0] w_inc, w_dec, w_add, w_next;
  logic [7:0] r_value;
  logic r_chg;
  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce_mod #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_deb (
      .i_clk(CLK),
      .i_rst(RST),
      .i_key_n(KEY_n[g]),
      .o_state(key_state[g]),
      .o_press(w_press[g])
    );
  end
  // 9-bit arithmetic so value+10 cannot overflow before the range compare
  always_comb begin
    w_v9 = {1'b0, r_value};
    w_add9 = w_v9 + 9'd10;
    w_inc = (w_v9 == MAX9) ? 8'd0 : r_value + 8'd1;
    w_dec = (r_value == 8'd0) ? MAX9[7:0] : r_value - 8'd1;
    w_add = (w_add9 > MAX9) ? 8'(w_add9 - MAX9 - 9'd1) : w_add9[7:0];
    w_next = w_press[KEY_CLR]   ? 8'd0 :
             w_press[KEY_INC]   ? w_inc :
             w_press[KEY_DEC]   ? w_dec :
             w_press[KEY_ADD10] ? w_add : r_value;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_value <= 8'(INIT_VALUE);
      r_chg <= 1'b0;
    end else begin
      r_value <= w_next;
      r_chg <= w_next != r_value;
    end
  end
  assign key_press = w_press;
  assign value = r_value;
  assign value_chg = r_chg;
endmodule
